// File: rtl/lza_normalizer_if.sv
// Adder-to-normalizer-to-rounder handshake and payload bundle for lza_normalizer.
interface lza_normalizer_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
);
  localparam int W  = 3*PARM_MANT + 5;
  localparam int EW = PARM_EXP + 2;

  logic              valid_i;
  logic              ready_o;
  logic [W-1:0]      A_LZA_i;
  logic [EW-1:0]     Exp_i;
  logic              Sign_i;
  logic              Minus_sticky_bit_i;

  logic              valid_o;
  logic              ready_i;
  logic [PARM_MANT:0] Mant_o;
  logic              Guard_o;
  logic              Round_o;
  logic              Sticky_o;
  logic [EW-1:0]     Exp_o;
  logic              Sign_o;
  logic              Zero_o;
  logic              Denorm_o;

  modport slave (
    input  valid_i, A_LZA_i, Exp_i, Sign_i, Minus_sticky_bit_i, ready_i,
    output ready_o, valid_o, Mant_o, Guard_o, Round_o, Sticky_o, Exp_o,
           Sign_o, Zero_o, Denorm_o
  );

  modport master (
    output valid_i, A_LZA_i, Exp_i, Sign_i, Minus_sticky_bit_i, ready_i,
    input  ready_o, valid_o, Mant_o, Guard_o, Round_o, Sticky_o, Exp_o,
           Sign_o, Zero_o, Denorm_o
  );
endinterface

// File: rtl/lza_normalizer.sv
// Two-stage normalizer: S1 leading-zero count, S2 left shift + exponent adjust.
// Define LZA_NORM_SUBNORMAL_EN to clamp the shift and flag subnormal results.
module lza_normalizer #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
) (
  input logic             clk_i,
  input logic             rst_i,
  lza_normalizer_if.slave bus
);
  localparam int W  = 3*PARM_MANT + 5;
  localparam int EW = PARM_EXP + 2;

  logic          s1_valid, s2_valid, s2_ready;
  logic [W-1:0]  s1_sum, s2_sum;
  logic [EW-1:0] s1_exp, s2_exp;
  logic          s1_sign, s2_sign, s1_ms, s2_ms;
  logic [6:0]    s1_lzc, s2_lzc;

  logic [6:0]    s2_shamt;
  logic [W-1:0]  s2_norm;
  logic [EW-1:0] s2_exp_adj;
  logic          s2_zero, s2_den;

  assign s2_ready    = ~s2_valid | bus.ready_i;
  assign bus.ready_o = ~s1_valid | s2_ready;

  // Lowest-to-highest scan so the most significant set bit wins.
  always_comb begin
    s1_lzc = 7'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (s1_sum[i]) s1_lzc = 7'(W - 1 - i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s1_ms    <= 1'b0;
    end else if (bus.ready_o) begin
      s1_valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1_sum  <= bus.A_LZA_i;
        s1_exp  <= bus.Exp_i;
        s1_sign <= bus.Sign_i;
        s1_ms   <= bus.Minus_sticky_bit_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_exp   <= '0;
      s2_sign  <= 1'b0;
      s2_ms    <= 1'b0;
      s2_lzc   <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum  <= s1_sum;
        s2_exp  <= s1_exp;
        s2_sign <= s1_sign;
        s2_ms   <= s1_ms;
        s2_lzc  <= s1_lzc;
      end
    end
  end

`ifdef LZA_NORM_SUBNORMAL_EN
  localparam int DW = EW + 8;
  logic signed [DW-1:0] exp_ext, exp_minus_lzc;
  assign exp_ext       = DW'($signed(s2_exp));
  assign exp_minus_lzc = exp_ext - $signed(DW'(s2_lzc));
`endif

  // Zero is keyed on lzc == W, so the all-zero reset state (lzc = 0) reads as non-zero
  // data with zero payload and every output stays 0.
  always_comb begin
    s2_zero    = (s2_lzc == 7'(W));
    s2_shamt   = s2_lzc;
    s2_den     = 1'b0;
    s2_exp_adj = s2_exp - EW'(s2_lzc);
`ifdef LZA_NORM_SUBNORMAL_EN
    if ((|s2_sum) && (exp_minus_lzc < 1)) begin
      s2_den     = 1'b1;
      s2_exp_adj = '0;
      s2_shamt   = (exp_ext > 1) ? 7'(exp_ext - 1) : '0;
    end
`endif
    if (s2_zero) s2_exp_adj = '0;
    s2_norm = s2_sum << s2_shamt;
  end

  assign bus.valid_o  = s2_valid;
  assign bus.Mant_o   = s2_norm[W-1 -: PARM_MANT+1];
  assign bus.Guard_o  = s2_norm[W-PARM_MANT-2];
  assign bus.Round_o  = s2_norm[W-PARM_MANT-3];
  assign bus.Sticky_o = (|s2_norm[W-PARM_MANT-4:0]) | s2_ms;
  assign bus.Exp_o    = s2_exp_adj;
  assign bus.Sign_o   = s2_sign;
  assign bus.Zero_o   = s2_zero;
  assign bus.Denorm_o = s2_den;
endmodule
